gray_code_counter: RTL

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_code_pkg.sv | 21 ++
 rtl/bin2gray_enc.sv | 13 +
 rtl/gray_code_counter.sv | 102 ++++++++++
 3 files changed

// File: rtl/gray_code_pkg.sv
// Shared constants and Gray/binary conversion helpers for the Gray code counter.
package gray_code_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
    localparam int unsigned GRAY_MAX_WIDTH     = 16;

    // Narrower callers zero-extend in and truncate out; upper bits stay zero.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational binary-to-Gray encoder feeding the gray_out register.
module bin2gray_enc
    import gray_code_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray_c
);

    assign o_gray_c = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(i_bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down Gray code counter with load, ready/valid output handshake and wrap flag.
module gray_code_counter
    import gray_code_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic             gray_valid,
    input  logic             gray_ready,
    output logic             wrap,
    output logic [WIDTH-1:0] count_bin
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_FULL  = 1'b1;
    localparam logic [WIDTH-1:0] C_MAX    = '1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             w_accept;
    logic             w_fire;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic             w_wrap_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accept decode, next count/wrap and next output state.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_accept    = (r_state == ST_EMPTY) || gray_ready;
        w_fire      = w_accept && (load || en);

        if (load) begin
            w_count_nxt = load_val;
        end else if (up_dn) begin
            w_count_nxt = r_count + WIDTH'(1);
            w_wrap_nxt  = (r_count == C_MAX);
        end else begin
            w_count_nxt = r_count - WIDTH'(1);
            w_wrap_nxt  = (r_count == '0);
        end

        case (r_state)
            ST_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (gray_ready) begin
                    w_state_nxt = w_fire ? ST_FULL : ST_EMPTY;
                end
            end
        endcase
    end

    bin2gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_bin    (w_count_nxt),
        .o_gray_c (w_gray_nxt)
    );

    // Outputs only move on an accepted request; wrap is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else if (w_fire) begin
            r_count <= w_count_nxt;
            r_gray  <= w_gray_nxt;
            r_wrap  <= w_wrap_nxt;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign gray_out   = r_gray;
    assign count_bin  = r_count;
    assign wrap       = r_wrap;
    assign gray_valid = r_state[0];

endmodule
